// File: rtl/sayac_imm_pkg.sv
// Shared definitions for the SAYAC immediate generator: mode encodings and
// the parameter legality check used at elaboration time.
package sayac_imm_pkg;

  typedef enum logic [2:0] {
    IMM_ZERO = 3'd0,
    IMM_SE5  = 3'd1,
    IMM_SE6  = 3'd2,
    IMM_SE8  = 3'd3,
    IMM_USE8 = 3'd4,
    IMM_CAT  = 3'd5,
    IMM_PFX  = 3'd6,
    IMM_RSVD = 3'd7
  } imm_mode_e;

  // Data width must be a whole number of fields, hold at least two fields
  // (so CAT fits and there is room for one prefix byte), and the field must
  // be wide enough for the SE6 mode.
  function automatic bit imm_widths_ok(input int data_w, input int field_w);
    return (field_w >= 6) && (data_w >= 2 * field_w) && ((data_w % field_w) == 0);
  endfunction

endpackage

// File: rtl/sayac_imm_ext.sv
// Combinational extension of the instruction immediate fields to DATA_W.
module sayac_imm_ext
  import sayac_imm_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int FIELD_W = 8
) (
  input  logic [2:0]         mode,
  input  logic [FIELD_W-1:0] field_a,
  input  logic [FIELD_W-1:0] field_b,
  output logic [DATA_W-1:0]  ext
);

  // Select the extension per mode; ZERO, PFX and the reserved code give zero.
  always_comb begin
    ext = '0;
    case (mode)
      IMM_SE5:  ext = {{(DATA_W-5){field_a[4]}}, field_a[4:0]};
      IMM_SE6:  ext = {{(DATA_W-6){field_a[5]}}, field_a[5:0]};
      IMM_SE8:  ext = {{(DATA_W-FIELD_W){field_a[FIELD_W-1]}}, field_a};
      IMM_USE8: ext[FIELD_W-1:0] = field_a;
      IMM_CAT:  ext[2*FIELD_W-1:0] = {field_a, field_b};
      default:  ext = '0;
    endcase
  end

endmodule

// File: rtl/sayac_imm_seq.sv
// Registered immediate generator with prefix accumulation and a valid/ready
// output stage. Prefix instructions collect upper bytes; the next extending
// instruction appends field_a and emits the full-width value.
module sayac_imm_seq
  import sayac_imm_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int FIELD_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         mode,
  input  logic [FIELD_W-1:0] field_a,
  input  logic [FIELD_W-1:0] field_b,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_imm,
  output logic               prefix_pending,
  output logic               pfx_overflow
);

  localparam int PW    = DATA_W - FIELD_W;
  localparam int NPFX  = PW / FIELD_W;
  localparam int CNT_W = $clog2(NPFX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NPFX);

  generate
    if (!imm_widths_ok(DATA_W, FIELD_W)) begin : g_bad_params
      $error("sayac_imm_seq: illegal DATA_W/FIELD_W combination");
    end
  endgenerate

  logic [PW-1:0]     pr_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              out_valid_reg;
  logic [DATA_W-1:0] out_imm_reg;
  logic              ovf_reg;

  logic [DATA_W-1:0] ext;
  logic [PW-1:0]     pr_shift;
  logic              accept;
  logic              is_pfx;
  logic              cnt_full;

  sayac_imm_ext #(
    .DATA_W (DATA_W),
    .FIELD_W(FIELD_W)
  ) u_ext (
    .mode   (mode),
    .field_a(field_a),
    .field_b(field_b),
    .ext    (ext)
  );

  // An empty prefix counter means PR is treated as zero before the shift,
  // so stale bytes never leak into the upper bits of a later result.
  generate
    if (NPFX == 1) begin : g_pr_single
      assign pr_shift = field_a;
    end else begin : g_pr_multi
      assign pr_shift = {(cnt_reg == '0) ? {(PW-FIELD_W){1'b0}} : pr_reg[PW-FIELD_W-1:0],
                         field_a};
    end
  endgenerate

  assign in_ready       = !flush && (!out_valid_reg || out_ready);
  assign accept         = in_valid && in_ready;
  assign is_pfx         = (mode == IMM_PFX);
  assign cnt_full       = (cnt_reg == CNT_MAX);
  assign out_valid      = out_valid_reg;
  assign out_imm        = out_imm_reg;
  assign prefix_pending = (cnt_reg != '0);
  assign pfx_overflow   = ovf_reg;

  // Prefix state, output register and handshake; flush beats any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      pr_reg        <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_imm_reg   <= '0;
      ovf_reg       <= 1'b0;
    end else if (flush) begin
      pr_reg        <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      ovf_reg <= 1'b0;
      if (accept && is_pfx) begin
        pr_reg        <= pr_shift;
        cnt_reg       <= cnt_full ? cnt_reg : cnt_reg + 1'b1;
        ovf_reg       <= cnt_full;
        out_valid_reg <= 1'b0;
      end else if (accept) begin
        out_imm_reg   <= (cnt_reg != '0) ? {pr_reg, field_a} : ext;
        out_valid_reg <= 1'b1;
        pr_reg        <= '0;
        cnt_reg       <= '0;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sayac_imm_seq.sv
// Directed bench for sayac_imm_seq with a 16-bit and a 32-bit instance.
// Expected results are queued when a request is accepted and compared when
// the consumer takes the output.
module tb_sayac_imm_seq;
  import sayac_imm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mode;
  logic [7:0]  field_a, field_b;
  logic        flush, out_ready;
  logic        in_valid16, in_valid32;
  logic        rdy16, rdy32, v16, v32, pp16, pp32, ovf16, ovf32;
  logic [15:0] imm16;
  logic [31:0] imm32;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] q16[$];
  logic [31:0] q32[$];

  always #5 clk = ~clk;

  sayac_imm_seq #(.DATA_W(16), .FIELD_W(8)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(rdy16), .mode(mode),
    .field_a(field_a), .field_b(field_b), .flush(flush), .out_valid(v16),
    .out_ready(out_ready), .out_imm(imm16), .prefix_pending(pp16), .pfx_overflow(ovf16)
  );

  sayac_imm_seq #(.DATA_W(32), .FIELD_W(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(rdy32), .mode(mode),
    .field_a(field_a), .field_b(field_b), .flush(flush), .out_valid(v32),
    .out_ready(out_ready), .out_imm(imm32), .prefix_pending(pp32), .pfx_overflow(ovf32)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Present one request to the selected instance and hold it until taken.
  task automatic send(input bit sel, input logic [2:0] m, input logic [7:0] a,
                      input logic [7:0] b, input logic [31:0] exp, input bit push);
    int n;
    n = 0;
    mode = m; field_a = a; field_b = b;
    if (sel) in_valid32 = 1'b1; else in_valid16 = 1'b1;
    #1;
    while (!(sel ? rdy32 : rdy16) && n < 20) begin
      step(1);
      n++;
    end
    n_vec++;
    assert (n < 20) else begin
      n_err++;
      $error("FAIL accept_timeout: observed %0d waits expected <20", n);
    end
    if (push) begin
      if (sel) q32.push_back(exp); else q16.push_back(exp);
    end
    step(1);
    in_valid16 = 1'b0; in_valid32 = 1'b0;
    if (push) check(sel ? "latency32" : "latency16", {31'b0, sel ? v32 : v16}, 32'd1);
  endtask

  // Output monitor: every completed transfer must match the queue head.
  always @(negedge clk) begin
    if (!rst && !flush && out_ready) begin
      if (v16) begin
        n_vec++;
        assert (q16.size() != 0) else begin
          n_err++;
          $error("FAIL spurious16: observed %h expected no output", imm16);
        end
        if (q16.size() != 0) check("out16", {16'b0, imm16}, q16.pop_front());
      end
      if (v32) begin
        n_vec++;
        assert (q32.size() != 0) else begin
          n_err++;
          $error("FAIL spurious32: observed %h expected no output", imm32);
        end
        if (q32.size() != 0) check("out32", imm32, q32.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid16 = 1'b0; in_valid32 = 1'b0;
    mode = 3'd0; field_a = 8'h00; field_b = 8'h00;
    step(2);
    check("rst_valid16", {31'b0, v16}, 32'd0);
    check("rst_imm16", {16'b0, imm16}, 32'h0);
    check("rst_pp16", {31'b0, pp16}, 32'd0);
    check("rst_imm32", imm32, 32'h0);
    rst = 1'b0;
    out_ready = 1'b1;
    step(1);

    // Basic extension modes
    send(0, IMM_SE5,  8'h15, 8'h00, 32'h0000FFF5, 1);
    send(0, IMM_USE8, 8'h80, 8'h00, 32'h00000080, 1);
    send(0, IMM_SE6,  8'h20, 8'h00, 32'h0000FFE0, 1);
    send(0, IMM_ZERO, 8'hFF, 8'hFF, 32'h00000000, 1);
    step(2);

    // Prefix then completing instruction
    send(0, IMM_PFX, 8'h12, 8'h00, 32'h0, 0);
    check("pp_after_pfx", {31'b0, pp16}, 32'd1);
    check("no_out_pfx", {31'b0, v16}, 32'd0);
    send(0, IMM_USE8, 8'h34, 8'h00, 32'h00001234, 1);
    check("pp_cleared", {31'b0, pp16}, 32'd0);
    step(3);

    // Backpressure holds the result and blocks input
    out_ready = 1'b0;
    send(0, IMM_SE8, 8'h80, 8'h00, 32'h0000FF80, 1);
    mode = IMM_CAT; field_a = 8'hAB; field_b = 8'hCD; in_valid16 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_imm", {16'b0, imm16}, 32'h0000FF80);
      check("bp_ready", {31'b0, rdy16}, 32'd0);
      step(1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'b0, rdy16}, 32'd1);
    q16.push_back(32'h0000ABCD);
    step(1);
    in_valid16 = 1'b0;
    check("cat_valid", {31'b0, v16}, 32'd1);
    step(3);

    // Flush discards a pending prefix and blocks the concurrent request
    send(0, IMM_PFX, 8'h55, 8'h00, 32'h0, 0);
    flush = 1'b1; mode = IMM_CAT; field_a = 8'h01; field_b = 8'h02; in_valid16 = 1'b1;
    #1;
    check("flush_ready", {31'b0, rdy16}, 32'd0);
    step(1);
    flush = 1'b0; in_valid16 = 1'b0;
    check("flush_pp", {31'b0, pp16}, 32'd0);
    step(2);
    check("flush_no_out", {31'b0, v16}, 32'd0);
    send(0, IMM_USE8, 8'h01, 8'h00, 32'h00000001, 1);
    step(2);

    // 16-bit: second prefix overflows the single prefix byte
    send(0, IMM_PFX, 8'h12, 8'h00, 32'h0, 0);
    check("ovf16_none", {31'b0, ovf16}, 32'd0);
    send(0, IMM_PFX, 8'h34, 8'h00, 32'h0, 0);
    check("ovf16_pulse", {31'b0, ovf16}, 32'd1);
    send(0, IMM_USE8, 8'h56, 8'h00, 32'h00003456, 1);
    check("ovf16_clear", {31'b0, ovf16}, 32'd0);
    step(2);

    // 32-bit: three prefixes complete with SE6 (extension ignored)
    send(1, IMM_PFX, 8'hAA, 8'h00, 32'h0, 0);
    send(1, IMM_PFX, 8'hBB, 8'h00, 32'h0, 0);
    send(1, IMM_PFX, 8'hCC, 8'h00, 32'h0, 0);
    check("ovf32_full", {31'b0, ovf32}, 32'd0);
    send(1, IMM_SE6, 8'hDD, 8'h00, 32'hAABBCCDD, 1);
    step(2);

    // 32-bit: four prefixes lose the oldest byte exactly once
    send(1, IMM_PFX, 8'h11, 8'h00, 32'h0, 0);
    send(1, IMM_PFX, 8'h22, 8'h00, 32'h0, 0);
    send(1, IMM_PFX, 8'h33, 8'h00, 32'h0, 0);
    check("ovf32_pre", {31'b0, ovf32}, 32'd0);
    send(1, IMM_PFX, 8'h44, 8'h00, 32'h0, 0);
    check("ovf32_pulse", {31'b0, ovf32}, 32'd1);
    step(1);
    check("ovf32_one_cycle", {31'b0, ovf32}, 32'd0);
    send(1, IMM_USE8, 8'h55, 8'h00, 32'h22334455, 1);
    step(2);

    // Reset with a held result, then reset mid-prefix
    out_ready = 1'b0;
    send(1, IMM_USE8, 8'h77, 8'h00, 32'h0, 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst_held_valid", {31'b0, v32}, 32'd0);
    check("rst_held_imm", imm32, 32'h0);
    out_ready = 1'b1;
    send(1, IMM_PFX, 8'h01, 8'h00, 32'h0, 0);
    send(1, IMM_PFX, 8'h02, 8'h00, 32'h0, 0);
    check("pp32_set", {31'b0, pp32}, 32'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst_pp32", {31'b0, pp32}, 32'd0);
    check("rst_ovf32", {31'b0, ovf32}, 32'd0);
    send(1, IMM_USE8, 8'h03, 8'h00, 32'h00000003, 1);
    step(3);

    check("q16_drained", q16.size(), 32'd0);
    check("q32_drained", q32.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sayac_imm_seq.md
# sayac_imm_seq

Registered, parametrised immediate generator for the SAYAC decode stage. It extends the 5/6/8-bit sign- and zero-extension and the two-field concatenation modes to a configurable data width. It adds a prefix mode: one or more prefix instructions accumulate upper immediate bits, and the next extending instruction completes the full-width value. The output is registered behind a valid/ready handshake, so decode can stall against the register-read/execute boundary.

## Interface
Parameters:
- DATA_W, 16, width of the produced immediate; multiple of FIELD_W, at least 2*FIELD_W.
- FIELD_W, 8, width of each instruction immediate field.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  decode presents an immediate request.
- in_ready  out  1  block accepts the request this cycle.
- mode  in  3  extension mode (encodings under Operation).
- field_a  in  FIELD_W  primary immediate field.
- field_b  in  FIELD_W  secondary field; used only by CAT.
- flush  in  1  pipeline flush: discard pending prefix and output.
- out_valid  out  1  out_imm holds a result.
- out_ready  in  1  consumer takes the result.
- out_imm  out  DATA_W  immediate result.
- prefix_pending  out  1  at least one prefix byte is held.
- pfx_overflow  out  1  one-cycle pulse when a prefix byte is shifted out and lost.

## Operation
- Mode encodings:
  - 0 ZERO: result is all zeros.
  - 1 SE5: sign-extend field_a[4:0].
  - 2 SE6: sign-extend field_a[5:0].
  - 3 SE8: sign-extend field_a[FIELD_W-1:0].
  - 4 USE8: zero-extend field_a.
  - 5 CAT: {field_a, field_b}, zero-extended to DATA_W.
  - 6 PFX: record field_a as a prefix; produces no output.
  - 7: reserved; behaves as ZERO.
- The prefix register PR is PW = DATA_W-FIELD_W bits wide. A saturating counter cnt runs from 0 to PW/FIELD_W.
- Accepted PFX:
  - PR <= {PR[PW-FIELD_W-1:0], field_a}.
  - cnt increments, saturating at its maximum.
  - If cnt was already at the maximum, the oldest byte is lost and pfx_overflow pulses.
  - When cnt is 0, PR is treated as zero before the shift, so unused upper bits are always zero.
- Accepted non-PFX mode with cnt>0:
  - out_imm <= {PR, field_a}; the mode's own extension is ignored.
  - cnt and PR clear to 0.
  - Modes 0 and 7 also consume the prefix this way.
- Accepted non-PFX mode with cnt=0: out_imm <= extended result.
- in_ready = !flush && (!out_valid || out_ready).
- out_valid next state:
  - 1 after an accepted non-PFX request.
  - 0 after a completed transfer with no new result, or after an accepted PFX while the old result drains.
- flush: out_valid <= 0, cnt <= 0, PR <= 0. No input is accepted that cycle, and flush overrides a simultaneous transfer.
- out_imm holds its value when out_valid=0, except on reset.

## Timing
- Latency 1 cycle from accepted input to out_valid. Throughput 1 result per cycle when out_ready is held high.
- PFX takes one accepted cycle and emits no output. prefix_pending is set the cycle after acceptance.
- While out_valid=1 and out_ready=0: out_imm is stable and in_ready=0.
- Reset state: out_valid=0, out_imm=0, cnt=0, PR=0, prefix_pending=0, pfx_overflow=0. Reset mid-prefix discards the prefix.
- pfx_overflow is registered and lasts one cycle.

## Structure
- Package sayac_imm_pkg holds the mode encodings (IMM_ZERO … IMM_PFX) and the DATA_W/FIELD_W legality check function.
- Sub-module sayac_imm_ext: purely combinational extension of field_a/field_b per mode to DATA_W.
- The top level contains the PR/cnt prefix state, the output register, and the handshake.

## Test plan
Defaults are DATA_W=16, FIELD_W=8 unless stated.
- Reset, then SE5 with field_a=0x15 and out_ready=1 -> the next cycle out_valid=1, out_imm=0xFFF5. USE8 0x80 -> 0x0080. SE6 0x20 -> 0xFFE0.
- PFX a=0x12, then USE8 a=0x34 -> exactly one output, 0x1234. prefix_pending is 1 between the two and 0 afterwards.
- Backpressure: SE8 0x80 with out_ready=0 for 3 cycles -> out_imm stays 0xFF80 and in_ready=0 throughout. A held CAT a=0xAB b=0xCD is accepted on release, giving 0xABCD next.
- Flush: PFX 0x55, then flush together with an in_valid CAT -> no output, prefix_pending=0. A following USE8 0x01 -> 0x0001.
- DATA_W=32: PFX 0xAA, 0xBB, 0xCC, then SE6 a=0xDD -> 0xAABBCCDD. Four PFX 0x11 to 0x44 -> pfx_overflow pulses once, and USE8 0x55 -> 0x22334455.
- Reset asserted with out_valid=1 and cnt=2 -> all outputs zero the next cycle.
